// File: rtl/axi4_arch_sender_pkg.sv
// rtl/axi4_arch_sender_pkg.sv - shared types and constants for the read-address sender
package axi4_arch_sender_pkg;

  localparam int DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } ar_state_e;

  // A lookup decision drops unless it explicitly accepts; an explicit drop always wins.
  function automatic logic is_drop_decision(input logic accept, input logic drop);
    return drop | ~accept;
  endfunction

endpackage

// File: rtl/axi4_arch_sender_if.sv
// rtl/axi4_arch_sender_if.sv - upstream and downstream AR channel bundle
interface axi4_arch_sender_if #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4
);

  logic [C_AXI_ID_WIDTH-1:0]   s_axi4_arid;
  logic [7:0]                  s_axi4_arlen;
  logic [2:0]                  s_axi4_arsize;
  logic [1:0]                  s_axi4_arburst;
  logic                        s_axi4_arlock;
  logic [3:0]                  s_axi4_arcache;
  logic [2:0]                  s_axi4_arprot;
  logic [C_AXI_USER_WIDTH-1:0] s_axi4_aruser;
  logic                        s_axi4_arvalid;
  logic                        s_axi4_arready;

  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_arid;
  logic [C_AXI_ADDR_WIDTH-1:0] m_axi4_araddr;
  logic [7:0]                  m_axi4_arlen;
  logic [2:0]                  m_axi4_arsize;
  logic [1:0]                  m_axi4_arburst;
  logic                        m_axi4_arlock;
  logic [3:0]                  m_axi4_arcache;
  logic [2:0]                  m_axi4_arprot;
  logic [C_AXI_USER_WIDTH-1:0] m_axi4_aruser;
  logic                        m_axi4_arvalid;
  logic                        m_axi4_arready;

  // Sender view: consumes the upstream AR channel, drives the downstream AR channel.
  modport master (
    input  s_axi4_arid, s_axi4_arlen, s_axi4_arsize, s_axi4_arburst, s_axi4_arlock,
           s_axi4_arcache, s_axi4_arprot, s_axi4_aruser, s_axi4_arvalid,
    output s_axi4_arready,
    output m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize, m_axi4_arburst,
           m_axi4_arlock, m_axi4_arcache, m_axi4_arprot, m_axi4_aruser, m_axi4_arvalid,
    input  m_axi4_arready
  );

  // Environment view: upstream requester and downstream responder.
  modport slave (
    output s_axi4_arid, s_axi4_arlen, s_axi4_arsize, s_axi4_arburst, s_axi4_arlock,
           s_axi4_arcache, s_axi4_arprot, s_axi4_aruser, s_axi4_arvalid,
    input  s_axi4_arready,
    input  m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize, m_axi4_arburst,
           m_axi4_arlock, m_axi4_arcache, m_axi4_arprot, m_axi4_aruser, m_axi4_arvalid,
    output m_axi4_arready
  );

endinterface

// File: rtl/axi4_arch_sender.sv
// rtl/axi4_arch_sender.sv - forwards or drops read-address requests after the address lookup
module axi4_arch_sender
  import axi4_arch_sender_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  axi4_arch_sender_if.master          ar_bus,
  input  logic                        l1_done,
  input  logic                        l1_accept,
  input  logic                        l1_drop,
  input  logic [C_AXI_ADDR_WIDTH-1:0] l1_addr,
  output logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  output logic                        trans_drop,
  output logic [DROP_CNT_WIDTH-1:0]   drop_cnt
);

  ar_state_e state_q, state_d;
  logic      slot_free;
  logic      take;
  logic      take_drop;
  logic      take_fwd;

  logic [C_AXI_ID_WIDTH-1:0]   m_arid_q;
  logic [C_AXI_ADDR_WIDTH-1:0] m_araddr_q;
  logic [7:0]                  m_arlen_q;
  logic [2:0]                  m_arsize_q;
  logic [1:0]                  m_arburst_q;
  logic                        m_arlock_q;
  logic [3:0]                  m_arcache_q;
  logic [2:0]                  m_arprot_q;
  logic [C_AXI_USER_WIDTH-1:0] m_aruser_q;

  // State register; reset discards any pending forward without a handshake.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Acceptance and next state; a forward slot frees up in the same cycle it drains.
  always_comb begin
    state_d   = state_q;
    slot_free = 1'b1;
    if (state_q == ST_FORWARD) slot_free = ar_bus.m_axi4_arready;
    take      = axi4_arstn & l1_done & ar_bus.s_axi4_arvalid & slot_free;
    take_drop = take & is_drop_decision(l1_accept, l1_drop);
    take_fwd  = take & ~take_drop;
    if (take_drop)                                          state_d = ST_DROP;
    else if (take_fwd)                                      state_d = ST_FORWARD;
    else if (state_q == ST_FORWARD && !ar_bus.m_axi4_arready) state_d = ST_FORWARD;
    else                                                    state_d = ST_IDLE;
  end

  assign ar_bus.s_axi4_arready = take;
  assign ar_bus.m_axi4_arvalid = (state_q == ST_FORWARD);
  assign trans_drop            = (state_q == ST_DROP);

  // Downstream AR payload; only reloaded on a forward acceptance, so it holds under backpressure.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      m_arid_q    <= '0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      m_arsize_q  <= '0;
      m_arburst_q <= '0;
      m_arlock_q  <= 1'b0;
      m_arcache_q <= '0;
      m_arprot_q  <= '0;
      m_aruser_q  <= '0;
    end else if (take_fwd) begin
      m_arid_q    <= ar_bus.s_axi4_arid;
      m_araddr_q  <= l1_addr;
      m_arlen_q   <= ar_bus.s_axi4_arlen;
      m_arsize_q  <= ar_bus.s_axi4_arsize;
      m_arburst_q <= ar_bus.s_axi4_arburst;
      m_arlock_q  <= ar_bus.s_axi4_arlock;
      m_arcache_q <= ar_bus.s_axi4_arcache;
      m_arprot_q  <= ar_bus.s_axi4_arprot;
      m_aruser_q  <= ar_bus.s_axi4_aruser;
    end
  end

  assign ar_bus.m_axi4_arid    = m_arid_q;
  assign ar_bus.m_axi4_araddr  = m_araddr_q;
  assign ar_bus.m_axi4_arlen   = m_arlen_q;
  assign ar_bus.m_axi4_arsize  = m_arsize_q;
  assign ar_bus.m_axi4_arburst = m_arburst_q;
  assign ar_bus.m_axi4_arlock  = m_arlock_q;
  assign ar_bus.m_axi4_arcache = m_arcache_q;
  assign ar_bus.m_axi4_arprot  = m_arprot_q;
  assign ar_bus.m_axi4_aruser  = m_aruser_q;

  // Drop ID for the response sender; holds its last value between pulses.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn)    trans_id <= '0;
    else if (take_drop) trans_id <= ar_bus.s_axi4_arid;
  end

  // Saturating count of drop pulses.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn)                      drop_cnt <= '0;
    else if (trans_drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_axi4_arch_sender.sv
// tb/tb_axi4_arch_sender.sv - randomized and directed checks of axi4_arch_sender against a transaction model
module tb_axi4_arch_sender;

  logic        axi4_aclk;
  logic        axi4_arstn;
  logic        l1_done, l1_accept, l1_drop;
  logic [31:0] l1_addr;
  logic [3:0]  trans_id;
  logic        trans_drop;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b1;

  // Transaction model: at most one outstanding forward, one pending drop pulse.
  bit          exp_fwd  = 1'b0;
  bit          exp_drop = 1'b0;
  logic [3:0]  exp_drop_id;
  logic [3:0]  exp_id;
  logic [31:0] exp_addr;
  logic [7:0]  exp_len;
  logic [16:0] exp_misc;
  logic [15:0] m_cnt = 16'd0;
  bit          sr;

  axi4_arch_sender_if #(.C_AXI_ADDR_WIDTH(32), .C_AXI_ID_WIDTH(4), .C_AXI_USER_WIDTH(4)) ar_if ();

  axi4_arch_sender #(.C_AXI_ADDR_WIDTH(32), .C_AXI_ID_WIDTH(4), .C_AXI_USER_WIDTH(4)) dut (
    .axi4_aclk  (axi4_aclk),
    .axi4_arstn (axi4_arstn),
    .ar_bus     (ar_if),
    .l1_done    (l1_done),
    .l1_accept  (l1_accept),
    .l1_drop    (l1_drop),
    .l1_addr    (l1_addr),
    .trans_id   (trans_id),
    .trans_drop (trans_drop),
    .drop_cnt   (drop_cnt)
  );

  initial begin
    axi4_aclk = 1'b0;
    forever #5 axi4_aclk = ~axi4_aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] s_misc();
    return {ar_if.s_axi4_arsize, ar_if.s_axi4_arburst, ar_if.s_axi4_arlock,
            ar_if.s_axi4_arcache, ar_if.s_axi4_arprot, ar_if.s_axi4_aruser};
  endfunction

  function automatic logic [16:0] m_misc();
    return {ar_if.m_axi4_arsize, ar_if.m_axi4_arburst, ar_if.m_axi4_arlock,
            ar_if.m_axi4_arcache, ar_if.m_axi4_arprot, ar_if.m_axi4_aruser};
  endfunction

  // Scoreboard sampled mid-cycle.
  always @(negedge axi4_aclk) begin
    if (!axi4_arstn) begin
      exp_fwd  = 1'b0;
      exp_drop = 1'b0;
      m_cnt    = 16'd0;
      chk("rst_s_arready", 64'(ar_if.s_axi4_arready), 64'(0));
      chk("rst_m_arvalid", 64'(ar_if.m_axi4_arvalid), 64'(0));
    end else if (mon_en) begin
      chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
      chk("trans_drop", 64'(trans_drop), 64'(exp_drop));
      if (exp_drop) chk("trans_id", 64'(trans_id), 64'(exp_drop_id));
      if (exp_drop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      chk("m_arvalid", 64'(ar_if.m_axi4_arvalid), 64'(exp_fwd));
      if (exp_fwd) begin
        chk("m_arid", 64'(ar_if.m_axi4_arid), 64'(exp_id));
        chk("m_araddr", 64'(ar_if.m_axi4_araddr), 64'(exp_addr));
        chk("m_arlen", 64'(ar_if.m_axi4_arlen), 64'(exp_len));
        chk("m_armisc", 64'(m_misc()), 64'(exp_misc));
      end
      sr = l1_done && ar_if.s_axi4_arvalid && (!exp_fwd || ar_if.m_axi4_arready);
      chk("s_arready", 64'(ar_if.s_axi4_arready), 64'(sr));
      if (exp_fwd && ar_if.m_axi4_arready) exp_fwd = 1'b0;
      exp_drop = 1'b0;
      if (sr) begin
        if (l1_drop || !l1_accept) begin
          exp_drop    = 1'b1;
          exp_drop_id = ar_if.s_axi4_arid;
        end else begin
          exp_fwd  = 1'b1;
          exp_id   = ar_if.s_axi4_arid;
          exp_addr = l1_addr;
          exp_len  = ar_if.s_axi4_arlen;
          exp_misc = s_misc();
        end
      end
    end
  end

  task automatic set_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic acc, input logic drp);
    ar_if.s_axi4_arid    = id;
    ar_if.s_axi4_arlen   = len;
    ar_if.s_axi4_arsize  = 3'($urandom);
    ar_if.s_axi4_arburst = 2'($urandom);
    ar_if.s_axi4_arlock  = 1'($urandom);
    ar_if.s_axi4_arcache = 4'($urandom);
    ar_if.s_axi4_arprot  = 3'($urandom);
    ar_if.s_axi4_aruser  = 4'($urandom);
    l1_addr   = addr;
    l1_accept = acc;
    l1_drop   = drp;
  endtask

  // Present a request with a completed lookup and hold it until the handshake.
  task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic acc, input logic drp);
    bit got = 1'b0;
    set_req(id, addr, len, acc, drp);
    ar_if.s_axi4_arvalid = 1'b1;
    l1_done              = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge axi4_aclk);
      got = ar_if.s_axi4_arready;
    end
    if (!got) chk("send_handshake", 64'(0), 64'(1));
    @(posedge axi4_aclk); #1;
    ar_if.s_axi4_arvalid = 1'b0;
    l1_done              = 1'b0;
  endtask

  initial begin
    bit pend;
    bit hs;
    axi4_arstn           = 1'b0;
    ar_if.m_axi4_arready = 1'b1;
    set_req(4'd0, 32'd0, 8'd0, 1'b1, 1'b0);
    ar_if.s_axi4_arvalid = 1'b1;
    l1_done              = 1'b1;

    // Reset state, with a ready-to-go request held upstream.
    repeat (3) @(posedge axi4_aclk);
    #1;
    chk("rst_trans_drop", 64'(trans_drop), 64'(0));
    chk("rst_trans_id", 64'(trans_id), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    chk("rst_m_araddr", 64'(ar_if.m_axi4_araddr), 64'(0));
    ar_if.s_axi4_arvalid = 1'b0;
    l1_done              = 1'b0;
    axi4_arstn           = 1'b1;
    @(posedge axi4_aclk); #1;

    // Single forward with ready downstream.
    send(4'd3, 32'h8000_1000, 8'd7, 1'b1, 1'b0);
    @(negedge axi4_aclk);
    chk("fwd_m_arvalid", 64'(ar_if.m_axi4_arvalid), 64'(1));
    chk("fwd_m_araddr", 64'(ar_if.m_axi4_araddr), 64'h8000_1000);
    chk("fwd_m_arid", 64'(ar_if.m_axi4_arid), 64'(3));
    chk("fwd_m_arlen", 64'(ar_if.m_axi4_arlen), 64'(7));
    @(negedge axi4_aclk);
    chk("fwd_idle", 64'(ar_if.m_axi4_arvalid), 64'(0));
    @(posedge axi4_aclk); #1;

    // Single drop.
    send(4'd5, 32'h1234_0000, 8'd0, 1'b0, 1'b1);
    @(negedge axi4_aclk);
    chk("drop_pulse", 64'(trans_drop), 64'(1));
    chk("drop_id", 64'(trans_id), 64'(5));
    chk("drop_no_fwd", 64'(ar_if.m_axi4_arvalid), 64'(0));
    @(negedge axi4_aclk);
    chk("drop_pulse_end", 64'(trans_drop), 64'(0));
    chk("drop_cnt_1", 64'(drop_cnt), 64'(1));
    @(posedge axi4_aclk); #1;

    // Backpressure with a second lookup waiting.
    ar_if.m_axi4_arready = 1'b0;
    send(4'd1, 32'h0000_1000, 8'd3, 1'b1, 1'b0);
    set_req(4'd2, 32'h0000_2000, 8'd15, 1'b1, 1'b0);
    ar_if.s_axi4_arvalid = 1'b1;
    l1_done              = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge axi4_aclk);
      chk("bp_s_arready", 64'(ar_if.s_axi4_arready), 64'(0));
      chk("bp_m_araddr", 64'(ar_if.m_axi4_araddr), 64'h0000_1000);
    end
    @(posedge axi4_aclk); #1;
    ar_if.m_axi4_arready = 1'b1;
    @(negedge axi4_aclk);
    chk("bp_release_s_arready", 64'(ar_if.s_axi4_arready), 64'(1));
    @(posedge axi4_aclk); #1;
    ar_if.s_axi4_arvalid = 1'b0;
    l1_done              = 1'b0;
    @(negedge axi4_aclk);
    chk("bp_second_valid", 64'(ar_if.m_axi4_arvalid), 64'(1));
    chk("bp_second_addr", 64'(ar_if.m_axi4_araddr), 64'h0000_2000);
    chk("bp_second_id", 64'(ar_if.m_axi4_arid), 64'(2));
    @(posedge axi4_aclk); #1;

    // Three back-to-back drops.
    send(4'd1, 32'd0, 8'd0, 1'b0, 1'b1);
    send(4'd2, 32'd0, 8'd0, 1'b0, 1'b1);
    send(4'd3, 32'd0, 8'd0, 1'b0, 1'b1);
    @(negedge axi4_aclk);
    chk("b2b_third_id", 64'(trans_id), 64'(3));
    @(negedge axi4_aclk);
    chk("b2b_drop_cnt", 64'(drop_cnt), 64'(4));
    @(posedge axi4_aclk); #1;

    // Randomized traffic; requests hold until their handshake.
    pend = 1'b0;
    hs   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (pend && hs) pend = 1'b0;
      ar_if.m_axi4_arready = ($urandom_range(9) < 7);
      if (!pend && $urandom_range(3) != 0) begin
        pend = 1'b1;
        set_req(4'($urandom), $urandom, 8'($urandom), 1'($urandom), ($urandom_range(3) == 0));
        ar_if.s_axi4_arvalid = 1'b1;
        l1_done              = 1'($urandom);
      end else if (pend && !l1_done) begin
        l1_done = 1'($urandom);
      end else if (!pend) begin
        ar_if.s_axi4_arvalid = 1'b0;
        l1_done              = 1'($urandom);
      end
      @(negedge axi4_aclk);
      hs = ar_if.s_axi4_arready;
      @(posedge axi4_aclk); #1;
    end
    ar_if.s_axi4_arvalid = 1'b0;
    l1_done              = 1'b0;
    ar_if.m_axi4_arready = 1'b1;
    repeat (3) @(posedge axi4_aclk);
    #1;

    // Reset while a forward is stalled downstream.
    ar_if.m_axi4_arready = 1'b0;
    send(4'd6, 32'hA5A5_0000, 8'd1, 1'b1, 1'b0);
    set_req(4'd7, 32'h0000_7000, 8'd2, 1'b1, 1'b0);
    ar_if.s_axi4_arvalid = 1'b1;
    l1_done              = 1'b1;
    @(negedge axi4_aclk);
    chk("pre_rst_m_arvalid", 64'(ar_if.m_axi4_arvalid), 64'(1));
    #2;
    axi4_arstn = 1'b0;
    #1;
    chk("async_rst_m_arvalid", 64'(ar_if.m_axi4_arvalid), 64'(0));
    chk("async_rst_s_arready", 64'(ar_if.s_axi4_arready), 64'(0));
    chk("async_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    chk("async_rst_m_arid", 64'(ar_if.m_axi4_arid), 64'(0));
    repeat (2) @(posedge axi4_aclk);
    #1;
    ar_if.s_axi4_arvalid = 1'b0;
    l1_done              = 1'b0;
    ar_if.m_axi4_arready = 1'b1;
    axi4_arstn           = 1'b1;
    @(negedge axi4_aclk);
    chk("post_rst_m_arvalid", 64'(ar_if.m_axi4_arvalid), 64'(0));
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    @(posedge axi4_aclk); #1;

    // Bring the drop counter to 0xFFFE with a long continuous drop stream.
    mon_en               = 1'b0;
    set_req(4'd0, 32'd0, 8'd0, 1'b0, 1'b1);
    ar_if.s_axi4_arvalid = 1'b1;
    l1_done              = 1'b1;
    repeat (65534) @(posedge axi4_aclk);
    #1;
    ar_if.s_axi4_arvalid = 1'b0;
    l1_done              = 1'b0;
    repeat (2) @(posedge axi4_aclk);
    @(negedge axi4_aclk);
    chk("preload_drop_cnt", 64'(drop_cnt), 64'hFFFE);
    @(posedge axi4_aclk); #1;
    m_cnt    = 16'hFFFE;
    exp_fwd  = 1'b0;
    exp_drop = 1'b0;
    mon_en   = 1'b1;

    // Saturation, including accept+drop and a lookup with neither flag.
    send(4'd7, 32'd0, 8'd0, 1'b0, 1'b1);
    send(4'd8, 32'h0000_8000, 8'd4, 1'b1, 1'b1);
    @(negedge axi4_aclk);
    chk("both_flags_dropped", 64'(trans_drop), 64'(1));
    chk("both_flags_no_fwd", 64'(ar_if.m_axi4_arvalid), 64'(0));
    @(posedge axi4_aclk); #1;
    send(4'd9, 32'h0000_9000, 8'd5, 1'b0, 1'b0);
    repeat (3) @(negedge axi4_aclk);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
    chk("sat_last_id", 64'(trans_id), 64'(9));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
